// File: rtl/rv_deserializer.sv
// Serial-to-parallel converter: MSB-first bits assembled into WIDTH-bit words,
// delivered through a ready/valid output slot with one word of internal holding.
module rv_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       shift_enable,
  input  logic                       shift_in,
  input  logic                       frame_start,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(WIDTH)-1:0]   bit_count,
  output logic                       overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [CW-1:0]    r_bit_count;
  logic             r_pending;
  logic             r_overflow;

  logic [WIDTH-1:0] w_shreg_nxt;
  logic [WIDTH-1:0] w_data_nxt;
  logic             w_valid_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic             w_pending_nxt;
  logic             w_ovf_nxt;
  logic             w_slot_free;
  logic [WIDTH-1:0] w_word;

  // Next-state: clear wins, then a held word blocks the serial path, then framing, then shifting.
  always_comb begin
    w_slot_free   = !r_out_valid || out_ready;
    w_word        = {r_shreg[WIDTH-2:0], shift_in};
    w_shreg_nxt   = r_shreg;
    w_data_nxt    = r_out_data;
    w_valid_nxt   = r_out_valid && !out_ready;
    w_count_nxt   = r_bit_count;
    w_pending_nxt = r_pending;
    w_ovf_nxt     = r_overflow;
    if (clear) begin
      w_shreg_nxt   = {WIDTH{1'b0}};
      w_data_nxt    = {WIDTH{1'b0}};
      w_valid_nxt   = 1'b0;
      w_count_nxt   = {CW{1'b0}};
      w_pending_nxt = 1'b0;
      w_ovf_nxt     = 1'b0;
    end else if (r_pending) begin
      if (shift_enable) begin
        w_ovf_nxt = 1'b1;
      end else begin
        w_ovf_nxt = r_overflow;
      end
      if (frame_start) begin
        w_count_nxt = {CW{1'b0}};
      end else begin
        w_count_nxt = r_bit_count;
      end
      // The completed word waits in shreg until the output slot opens.
      if (w_slot_free) begin
        w_data_nxt    = r_shreg;
        w_valid_nxt   = 1'b1;
        w_pending_nxt = 1'b0;
      end else begin
        w_valid_nxt   = r_out_valid;
      end
    end else if (frame_start) begin
      if (shift_enable) begin
        w_shreg_nxt = {{(WIDTH-1){1'b0}}, shift_in};
        w_count_nxt = CW'(1);
      end else begin
        w_count_nxt = {CW{1'b0}};
      end
    end else if (shift_enable) begin
      if (r_bit_count == LAST_BIT) begin
        w_count_nxt = {CW{1'b0}};
        if (w_slot_free) begin
          w_data_nxt  = w_word;
          w_valid_nxt = 1'b1;
        end else begin
          w_shreg_nxt   = w_word;
          w_pending_nxt = 1'b1;
        end
      end else begin
        w_shreg_nxt = w_word;
        w_count_nxt = r_bit_count + CW'(1);
      end
    end else begin
      w_shreg_nxt = r_shreg;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shreg     <= {WIDTH{1'b0}};
      r_out_data  <= {WIDTH{1'b0}};
      r_out_valid <= 1'b0;
      r_bit_count <= {CW{1'b0}};
      r_pending   <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_shreg     <= w_shreg_nxt;
      r_out_data  <= w_data_nxt;
      r_out_valid <= w_valid_nxt;
      r_bit_count <= w_count_nxt;
      r_pending   <= w_pending_nxt;
      r_overflow  <= w_ovf_nxt;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign bit_count = r_bit_count;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_rv_deserializer.sv
// Self-checking bench for rv_deserializer: directed table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_rv_deserializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         clear;
  logic         shift_enable;
  logic         shift_in;
  logic         frame_start;
  logic         out_ready;
  logic         out_valid;
  logic         overflow;
  logic [W-1:0] out_data;
  logic [2:0]   bit_count;

  int total = 0;
  int bad   = 0;

  bit           m_part[$];
  logic [W-1:0] m_words[$];
  logic [W-1:0] m_data;
  bit           m_ovf;

  typedef struct {
    logic       se, si, fs, rdy, clr;
    logic       ev;
    logic [7:0] ed;
    logic [2:0] ec;
    logic       eo;
  } vec_t;

  vec_t tbl[9];

  always #5 clk = ~clk;

  rv_deserializer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .clear(clear), .shift_enable(shift_enable),
    .shift_in(shift_in), .frame_start(frame_start), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .bit_count(bit_count),
    .overflow(overflow)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_part.delete();
    m_words.delete();
    m_data = '0;
    m_ovf  = 1'b0;
  endfunction

  // Words live in a two-deep queue: front is the visible slot, second is the held word.
  function automatic void model_edge(input logic se, si, fs, rdy, clr);
    logic [W-1:0] w;
    bit pop;
    if (clr) begin
      model_reset();
    end else begin
      pop = (m_words.size() > 0) && rdy;
      if (m_words.size() == 2) begin
        if (se) m_ovf = 1'b1;
        if (fs) m_part.delete();
      end else if (fs) begin
        m_part.delete();
        if (se) m_part.push_back(si);
      end else if (se) begin
        m_part.push_back(si);
        if (m_part.size() == W) begin
          w = '0;
          foreach (m_part[i]) w = (w << 1) | W'(m_part[i]);
          m_words.push_back(w);
          m_part.delete();
        end
      end
      if (pop) void'(m_words.pop_front());
      if (m_words.size() > 0) m_data = m_words[0];
    end
  endfunction

  task automatic step(input logic se, si, fs, rdy, clr);
    shift_enable = se;
    shift_in     = si;
    frame_start  = fs;
    out_ready    = rdy;
    clear        = clr;
    @(posedge clk);
    model_edge(se, si, fs, rdy, clr);
    @(negedge clk);
    chk("model_valid", out_valid, (m_words.size() > 0));
    chk("model_data", out_data, m_data);
    chk("model_count", bit_count, m_part.size());
    chk("model_ovf", overflow, m_ovf);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic rdy);
    for (int i = 7; i >= 0; i--) step(1'b1, b[i], 1'b0, rdy, 1'b0);
  endtask

  initial begin
    logic [7:0] a5;
    logic [7:0] c3;
    logic [7:0] sbytes[3];
    logic [7:0] cur;
    logic se, fs, rdy, clr;

    a5 = 8'hA5;
    c3 = 8'hC3;
    sbytes[0] = 8'h12; sbytes[1] = 8'h34; sbytes[2] = 8'h56;

    rst = 1'b0; clear = 1'b0; shift_enable = 1'b0; shift_in = 1'b0;
    frame_start = 1'b0; out_ready = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_count", bit_count, 3'd0);
    chk("rst_ovf", overflow, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Basic word 0xA5 then one idle cycle.
    for (int i = 0; i < 8; i++) begin
      tbl[i].se = 1'b1; tbl[i].si = a5[7-i]; tbl[i].fs = 1'b0; tbl[i].rdy = 1'b1; tbl[i].clr = 1'b0;
      tbl[i].ev = (i == 7);
      tbl[i].ed = (i == 7) ? 8'hA5 : 8'h00;
      tbl[i].ec = 3'((i + 1) % 8);
      tbl[i].eo = 1'b0;
    end
    tbl[8].se = 1'b0; tbl[8].si = 1'b0; tbl[8].fs = 1'b0; tbl[8].rdy = 1'b1; tbl[8].clr = 1'b0;
    tbl[8].ev = 1'b0; tbl[8].ed = 8'hA5; tbl[8].ec = 3'd0; tbl[8].eo = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].se, tbl[i].si, tbl[i].fs, tbl[i].rdy, tbl[i].clr);
      chk("tbl_valid", out_valid, tbl[i].ev);
      chk("tbl_data", out_data, tbl[i].ed);
      chk("tbl_count", bit_count, tbl[i].ec);
      chk("tbl_ovf", overflow, tbl[i].eo);
    end

    // Streaming three words back to back.
    for (int k = 0; k < 24; k++) begin
      cur = sbytes[k / 8];
      step(1'b1, cur[7 - (k % 8)], 1'b0, 1'b1, 1'b0);
      chk("stream_valid", out_valid, (k % 8) == 7);
      if ((k % 8) == 7) chk("stream_data", out_data, cur);
    end
    chk("stream_ovf", overflow, 1'b0);

    // Backpressure: second word held, extra bit dropped.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_byte(8'h11, 1'b0);
    chk("bp_first_valid", out_valid, 1'b1);
    chk("bp_first_data", out_data, 8'h11);
    send_byte(8'h22, 1'b0);
    chk("bp_hold_data", out_data, 8'h11);
    chk("bp_hold_ovf", overflow, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("bp_drop_ovf", overflow, 1'b1);
    chk("bp_drop_count", bit_count, 3'd0);
    chk("bp_drop_data", out_data, 8'h11);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("bp_second_valid", out_valid, 1'b1);
    chk("bp_second_data", out_data, 8'h22);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("bp_drain_valid", out_valid, 1'b0);
    chk("bp_sticky_ovf", overflow, 1'b1);

    // Realign mid-word.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("ra_partial_count", bit_count, 3'd3);
    step(1'b1, c3[7], 1'b1, 1'b1, 1'b0);
    chk("ra_restart_count", bit_count, 3'd1);
    for (int i = 6; i >= 0; i--) step(1'b1, c3[i], 1'b0, 1'b1, 1'b0);
    chk("ra_valid", out_valid, 1'b1);
    chk("ra_data", out_data, 8'hC3);

    // frame_start with a bit at the last position restarts instead of completing.
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("fs_last_valid", out_valid, 1'b0);
    chk("fs_last_count", bit_count, 3'd1);

    // Clear with valid and overflow set, other inputs active.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_byte(8'h5A, 1'b0);
    send_byte(8'h3C, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("clr_pre_ovf", overflow, 1'b1);
    chk("clr_pre_valid", out_valid, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("clr_valid", out_valid, 1'b0);
    chk("clr_data", out_data, 8'h00);
    chk("clr_count", bit_count, 3'd0);
    chk("clr_ovf", overflow, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr_no_pending", out_valid, 1'b0);

    // Asynchronous reset mid-word, observed before any clock edge.
    send_byte(8'h96, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_data", out_data, 8'h00);
    chk("arst_count", bit_count, 3'd0);
    chk("arst_ovf", overflow, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("arst_restart_count", bit_count, 3'd1);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      se  = ($urandom_range(0, 9) < 7);
      fs  = ($urandom_range(0, 31) == 0);
      rdy = $urandom_range(0, 1);
      clr = ($urandom_range(0, 199) == 0);
      step(se, $urandom_range(0, 1), fs, rdy, clr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
